// File: rtl/chunk_pkg.sv
// Shared constants and state encoding for the chunked result transmitter.
package chunk_pkg;
  localparam int CHUNK_W    = 32;
  localparam int NUM_CHUNKS = 8;
  localparam int CNT_W      = 7;
  localparam logic [CNT_W-1:0] CNT_ERR = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    DRAIN  = 2'd2
  } state_e;
endpackage

// File: rtl/chunk_tx_if.sv
// Result handshake from the arithmetic unit plus the GPIO request/ack bus.
interface chunk_tx_if import chunk_pkg::*; #(
  parameter int CHUNK_W    = chunk_pkg::CHUNK_W,
  parameter int NUM_CHUNKS = chunk_pkg::NUM_CHUNKS,
  parameter int CNT_W      = chunk_pkg::CNT_W
);
  logic                                res_valid;
  logic                                res_ready;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]  res_data;
  logic [CNT_W-1:0]                    mb_cnt;
  logic [CNT_W-1:0]                    cnt;
  logic [CHUNK_W-1:0]                  out_chunk;

  modport master (output res_valid, res_data, mb_cnt,
                  input  res_ready, cnt, out_chunk);
  modport slave  (input  res_valid, res_data, mb_cnt,
                  output res_ready, cnt, out_chunk);
endinterface

// File: rtl/cnt_sync.sv
// Brings the MicroBlaze request index into clk and flags a new, settled request.
module cnt_sync import chunk_pkg::*; #(
  parameter int W = chunk_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] mb_cnt,
  input  logic [W-1:0] cur_cnt,
  output logic [W-1:0] req_idx,
  output logic         req_strobe
);
  logic [W-1:0] s1_q, s2_q, cmp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cmp_q <= '0;
    end else begin
      s1_q  <= mb_cnt;
      s2_q  <= s1_q;
      cmp_q <= s2_q;
    end
  end

  // Two equal synchronized samples filter out bits caught mid-transition.
  assign req_idx    = s2_q;
  assign req_strobe = (s2_q == cmp_q) && (s2_q != cur_cnt);
endmodule

// File: rtl/chunk_tx.sv
// Holds one wide result and serves it chunk by chunk to a GPIO request/ack bus.
module chunk_tx import chunk_pkg::*; #(
  parameter int CHUNK_W    = chunk_pkg::CHUNK_W,
  parameter int NUM_CHUNKS = chunk_pkg::NUM_CHUNKS,
  parameter int CNT_W      = chunk_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  chunk_tx_if.slave  bus
);
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] ERR  = CNT_W'(CNT_ERR);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS);

  state_e                             state_q, state_d;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [CHUNK_W-1:0]                 chunk_q, chunk_d;
  logic                               rdy_q, rdy_d;
  logic [CNT_W-1:0]                   req_idx;
  logic                               req_strobe;
  logic                               capture;
  logic [IDX_W-1:0]                   sel;

  cnt_sync #(.W(CNT_W)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .mb_cnt     (bus.mb_cnt),
    .cur_cnt    (cnt_q),
    .req_idx    (req_idx),
    .req_strobe (req_strobe)
  );

  assign capture = (state_q == IDLE) && rdy_q && bus.res_valid;
  assign sel     = req_idx[IDX_W-1:0] - IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      chunk_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      chunk_q <= chunk_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = LOADED;
      LOADED:  if (req_strobe && req_idx == LAST) state_d = DRAIN;
      DRAIN:   if (req_strobe && req_idx == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready follows IDLE one cycle late, so a release edge can never also capture.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    chunk_d = chunk_q;
    rdy_d   = (state_q == IDLE) && !capture;
    if (capture) buf_d = bus.res_data;
    if (req_strobe) begin
      if (req_idx == '0) begin
        cnt_d   = '0;
        chunk_d = '0;
      end else if (state_q == IDLE || req_idx > LAST) begin
        cnt_d   = ERR;
        chunk_d = '0;
      end else begin
        cnt_d   = req_idx;
        chunk_d = buf_q[sel];
      end
    end
  end

  assign bus.res_ready = rdy_q;
  assign bus.cnt       = cnt_q;
  assign bus.out_chunk = chunk_q;
endmodule

// File: tb/tb_chunk_tx.sv
// Scoreboarded bench for chunk_tx: load, serve, errors, glitch, release, reset.
`timescale 1ns/1ps
module tb_chunk_tx;
  import chunk_pkg::*;

  typedef struct {
    logic [6:0]  c;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];
  logic [6:0] last_cnt;
  logic [7:0][31:0] pat;

  chunk_tx_if bus ();

  chunk_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h req=%h", tag, act, exp);
    end
  endtask

  // Drive request k just after a falling edge; the ack must appear on the 4th rising edge.
  task automatic do_req(input logic [6:0] k, input logic [6:0] ec, input logic [31:0] eo);
    exp_t e, g;
    @(negedge clk);
    bus.mb_cnt = k;
    e.c = ec;
    e.d = eo;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1 chk($sformatf("hold_%0d", k), 32'(bus.cnt), 32'(last_cnt));
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk($sformatf("cnt_%0d", k), 32'(bus.cnt), 32'(g.c));
    chk($sformatf("chunk_%0d", k), bus.out_chunk, g.d);
    last_cnt = g.c;
  endtask

  task automatic load(input logic [7:0][31:0] d);
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    @(posedge clk);
    #1 chk("ready_after_cap", 32'(bus.res_ready), 32'd0);
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  initial begin
    exp_t g;
    n_chk = 0;
    n_fail = 0;
    last_cnt = 7'd0;
    reset = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.mb_cnt    = '0;
    for (int k = 0; k < 8; k++) pat[k] = 32'(k + 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(bus.cnt), 32'd0);
    chk("rst_chunk", bus.out_chunk, 32'd0);
    chk("rst_ready", 32'(bus.res_ready), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("ready_first_edge", 32'(bus.res_ready), 32'd1);

    load(pat);
    for (int k = 1; k <= 7; k++) do_req(7'(k), 7'(k), 32'(k));

    // New data offered while loaded must be ignored.
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.res_data  = {8{32'hDEAD_BEEF}};
    repeat (3) @(posedge clk);
    #1 chk("ready_loaded", 32'(bus.res_ready), 32'd0);
    @(negedge clk) bus.res_valid = 1'b0;

    do_req(7'd9,   CNT_ERR, 32'd0);
    do_req(7'd2,   7'd2,    32'd2);
    do_req(7'h7F,  CNT_ERR, 32'd0);
    do_req(7'd1,   7'd1,    32'd1);
    do_req(7'd8,   7'd8,    32'd8);
    do_req(7'd3,   7'd3,    32'd3);

    // One-cycle glitch to 5 must not be acknowledged.
    @(negedge clk) bus.mb_cnt = 7'd5;
    @(negedge clk) bus.mb_cnt = 7'd3;
    repeat (6) @(posedge clk);
    #1;
    chk("glitch_cnt", 32'(bus.cnt), 32'd3);
    chk("glitch_chunk", bus.out_chunk, 32'd3);
    chk("ready_drain", 32'(bus.res_ready), 32'd0);

    do_req(7'd0, 7'd0, 32'd0);
    @(posedge clk);
    #1 chk("ready_after_release", 32'(bus.res_ready), 32'd1);

    load({8{32'hFFFF_FFFF}});
    do_req(7'd3, 7'd3, 32'hFFFF_FFFF);
    do_req(7'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("ready_loaded_zero", 32'(bus.res_ready), 32'd0);
    do_req(7'd4, 7'd4, 32'hFFFF_FFFF);

    // Asynchronous reset mid-transfer, request 4 left on the bus.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.cnt), 32'd0);
    chk("mid_rst_chunk", bus.out_chunk, 32'd0);
    chk("mid_rst_ready", 32'(bus.res_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_cnt = 7'd0;
    g.c = CNT_ERR;
    g.d = 32'd0;
    sb.push_back(g);
    @(posedge clk);
    #1 chk("ready_post_rst", 32'(bus.res_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 chk("hold_post_rst", 32'(bus.cnt), 32'(last_cnt));
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("idle_req_cnt", 32'(bus.cnt), 32'(g.c));
    chk("idle_req_chunk", bus.out_chunk, g.d);
    chk("ready_idle", 32'(bus.res_ready), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/chunk_tx.md
CHUNK_TX -- requirements
Module: chunk_tx

Interface
REQ-001 Parameter CHUNK_W, default 32, width of one GPIO result chunk.
REQ-002 Parameter NUM_CHUNKS, default 8, chunks per result (256-bit result).
REQ-003 Parameter CNT_W, default 7, width of request/acknowledge index.
REQ-004 clk  input  1  single block clock (10 MHz arithmetic clock); all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 res_valid  input  1  arithmetic unit offers a complete result.
REQ-007 res_data  input  CHUNK_W*NUM_CHUNKS  result word; chunk k = bits [32k+31:32k].
REQ-008 res_ready  output  1  block can accept a result; transfer occurs when res_valid and res_ready are both high on a clock edge.
REQ-009 mb_cnt  input  CNT_W  request index from MicroBlaze GPIO; asynchronous to clk.
REQ-010 cnt  output  CNT_W  acknowledge index returned to MicroBlaze GPIO.
REQ-011 out_chunk  output  CHUNK_W  requested result chunk returned to MicroBlaze GPIO.

Function
REQ-012 States: IDLE (no result held), LOADED (result held, serving requests), DRAIN (last chunk served, awaiting release).
REQ-013 IDLE: res_ready=1, cnt=0, out_chunk=0; res_valid high captures res_data into buffer and enters LOADED next edge.
REQ-014 LOADED and DRAIN: res_ready=0; res_valid ignored, buffer unchanged.
REQ-015 mb_cnt passes through a 2-flop synchronizer then a third compare register; request accepted only when the last two synchronized samples are equal and differ from current cnt.
REQ-016 Latency: mb_cnt stable before edge N yields updated cnt/out_chunk after edge N+3 (4th edge); cnt and out_chunk change on the same edge.
REQ-017 Accepted request k in 1..NUM_CHUNKS while LOADED/DRAIN: out_chunk = chunk k-1, cnt = k.
REQ-018 Accepted request k > NUM_CHUNKS (including 7'h7F... excluding only 0): cnt = 7'h7F (error code), out_chunk = 0; state unchanged.
REQ-019 Accepted request k=NUM_CHUNKS while LOADED moves to DRAIN; chunks may be re-requested in any order in LOADED or DRAIN.
REQ-020 Accepted request 0 in DRAIN: buffer released, state IDLE, cnt=0, out_chunk=0 on that edge.
REQ-021 Accepted request 0 in LOADED: cnt=0, out_chunk=0, buffer kept, state LOADED.
REQ-022 Any nonzero request in IDLE: cnt = 7'h7F, out_chunk = 0.
REQ-023 Capture and release never coincide: IDLE entered from DRAIN asserts res_ready from the following cycle.

Reset
REQ-024 reset low: state IDLE, cnt=0, out_chunk=0, res_ready=0 while low, buffer and synchronizer flops cleared.
REQ-025 First edge after reset deasserts: res_ready=1; reset mid-transfer discards held result without acknowledgment.

Structure
REQ-026 Package chunk_pkg holds CHUNK_W, CNT_W, NUM_CHUNKS, CNT_ERR=7'h7F and the state enumeration.
REQ-027 Sub-module cnt_sync: 2-flop synchronizer plus stability compare, CNT_W wide, outputs req_idx and req_strobe.
REQ-028 Chunk select is a registered mux over the buffer; no combinational path from mb_cnt to outputs.

Verification
REQ-029 Load res_data = {32'h8..32'h1 pattern: chunk k = k+1}, mb_cnt 1..8 in sequence, wait cnt==mb_cnt -> out_chunk = 1..8, each ack exactly 4 edges after stable request.
REQ-030 After 8 served, mb_cnt=0 -> cnt=0, res_ready=1 next cycle; second result 256'hFFFF... then loads and mb_cnt=3 -> out_chunk=32'hFFFF_FFFF.
REQ-031 mb_cnt=9 and mb_cnt=7'h7F in LOADED -> cnt=7'h7F, out_chunk=0, subsequent mb_cnt=2 -> chunk 1 served.
REQ-032 mb_cnt toggles 3->5 for one cycle only (glitch) -> no acknowledgment of 5; cnt stays 3.
REQ-033 res_valid asserted in LOADED with new data -> ignored; mb_cnt=1 still returns original chunk 0.
REQ-034 reset low during LOADED after mb_cnt=4 ack -> cnt=0, out_chunk=0 immediately; after release res_ready=1 and mb_cnt=4 -> cnt=7'h7F.
